// File: rtl/reg_file_dump.sv
// Multi-port CPU register file with write-to-read bypass, optional hardwired x0,
// and a valid/ready debug port that streams every register once per request.
module reg_file_dump #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned AW       = $clog2(NREGS),
   parameter int unsigned NRP      = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRP*AW-1:0]   raddr,
   output logic [NRP*XLEN-1:0] rdata,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic                dump_start,
   output logic                dump_busy,
   output logic                dump_valid,
   input  logic                dump_ready,
   output logic [AW-1:0]       dump_idx,
   output logic [XLEN-1:0]     dump_data,
   output logic                dump_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   idx, idx_nxt;
   logic [XLEN-1:0] regs [NREGS];
   logic            wr_en;

   assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[waddr] <= wdata;
      end
   end

   // Zero-register check takes priority over bypass so a write to x0 never leaks through.
   for (genvar k = 0; k < NRP; k++) begin : g_rd
      logic [AW-1:0] a;
      assign a = raddr[k*AW +: AW];
      assign rdata[k*XLEN +: XLEN] =
         ((ZERO_REG != 0) && (a == '0))        ? '0    :
         ((BYPASS != 0) && we && (waddr == a)) ? wdata :
                                                 regs[a];
   end

   assign dump_data =
      ((ZERO_REG != 0) && (idx == '0))        ? '0    :
      ((BYPASS != 0) && we && (waddr == idx)) ? wdata :
                                                regs[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (dump_start) begin
               state_nxt = RUN;
               idx_nxt   = '0;
            end
         end
         RUN: begin
            if (dump_ready) begin
               if (idx == AW'(NREGS - 1)) state_nxt = DONE;
               else                       idx_nxt   = idx + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign dump_valid = (state == RUN);
   assign dump_done  = (state == DONE);
   assign dump_busy  = (state != IDLE);
   assign dump_idx   = idx;

endmodule
